// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the chunked add/subtract unit:
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - cnt_width : width of the chunk counter, max(1, clog2(n))
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one so the counter
    // still exists when the whole word is a single chunk.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : addsub_pkg

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Combinational CHUNK-bit ripple slice used by chunked_addsub.
// Ports:
//   a, b   : CHUNK-bit addends (b is already inverted for subtraction)
//   cin    : carry into the slice LSB
//   sum    : CHUNK-bit sum
//   cout   : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (overflow = c_msb ^ cout on the top slice)
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum   = full[CHUNK-1:0];
        cout  = full[CHUNK];
        // The sum bit is a ^ b ^ carry_in, so the carry into the MSB falls
        // out of the MSB bits without a second adder.
        c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
    end

endmodule : addsub_slice

// File: rtl/chunked_addsub.sv
// -----------------------------------------------------------------------------
// chunked_addsub
// WIDTH-bit add/subtract with carry-in, computed CHUNK bits per clock (LSB
// slice first) through a carry register, with carry/overflow/zero/negative
// flags. Valid/ready handshakes on both input and output sides.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   A, B, C, sub        : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   S, c4, v, z, n      : result, carry out, signed overflow, zero, negative
// -----------------------------------------------------------------------------
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c4,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int             NCHUNK = WIDTH / CHUNK;
    localparam int             CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0]  LAST   = CW'(NCHUNK - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] a_sl, b_sl, sum;
    logic             cout, c_msb;
    logic             accept, last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt == LAST);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ---------------- slice select ----------------
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    // Result with the current slice merged in; on the final slice this is the
    // complete word, so z and n are taken from it directly.
    always_comb begin
        s_nxt = s_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) s_nxt[i*CHUNK +: CHUNK] = sum;
        end
    end

    // ---------------- datapath ----------------
    // NOTE: operand registers are reset along with the visible outputs so an
    // aborted operation leaves no stale state; they are plain flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            s_q     <= '0;
            c4      <= 1'b0;
            v       <= 1'b0;
            z       <= 1'b0;
            n       <= 1'b0;
        end else if (accept) begin
            // Subtraction as A + ~B + ~C: condition B and the carry once here.
            a_q     <= A;
            b_q     <= B ^ {WIDTH{sub}};
            carry_q <= C ^ sub;
            cnt     <= '0;
        end else if (state == RUN) begin
            s_q     <= s_nxt;
            carry_q <= cout;
            cnt     <= cnt + CW'(1);
            if (last) begin
                c4 <= cout;
                v  <= cout ^ c_msb;
                z  <= (s_nxt == '0);
                n  <= s_nxt[WIDTH-1];
            end
        end
    end

    assign S = s_q;

endmodule : chunked_addsub

// File: tb/tb_chunked_addsub.sv
// -----------------------------------------------------------------------------
// tb_chunked_addsub
// Self-checking bench for chunked_addsub (WIDTH=16, CHUNK=4): directed vector
// table, randomized operations against an arithmetic reference model, plus
// backpressure and mid-operation reset sequences.
// -----------------------------------------------------------------------------
module tb_chunked_addsub;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] A, B;
    logic             C, sub;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] S;
    logic             c4, v, z, n;

    chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c4        (c4),
        .v         (v),
        .z         (z),
        .n         (n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a, b;
        logic             c, sub;
        logic [WIDTH-1:0] s;
        logic             c4, v, z, n;
    } vec_t;

    vec_t vecs[7];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: exact integer arithmetic, then read the flags off the result.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic sb,
                         output logic [WIDTH-1:0] s, output logic mc4,
                         output logic mv, output logic mz, output logic mn);
        int          sa, sbb, ci, r;
        int unsigned ua, ub, cu;
        sa  = int'($signed(a));
        sbb = int'($signed(b));
        ci  = c ? 1 : 0;
        ua  = a;
        ub  = b;
        cu  = c ? 1 : 0;
        if (!sb) begin
            r   = sa + sbb + ci;
            mc4 = (ua + ub + cu) > 32'd65535;
            s   = 16'(ua + ub + cu);
        end else begin
            r   = sa - sbb - ci;
            mc4 = (ua >= ub + cu);       // carry out set means no borrow
            s   = 16'(ua - ub - cu);
        end
        mv = (r > 32767) || (r < -32768);
        mz = (s == '0);
        mn = s[WIDTH-1];
    endtask

    // One full transaction: accept, measure latency, compare, hold, retire.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic sb, input int hold);
        logic [WIDTH-1:0] es;
        logic             ec4, ev, ez, en;
        int               lat;
        model(a, b, c, sb, es, ec4, ev, ez, en);
        @(negedge clk);
        A = a; B = b; C = c; sub = sb; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, NCHUNK);
        check({tag, " S"},  S,  es);
        check({tag, " c4"}, c4, ec4);
        check({tag, " v"},  v,  ev);
        check({tag, " z"},  z,  ez);
        check({tag, " n"},  n,  en);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " in_ready after retire"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        vec_t             t;

        // Directed vectors with hand-derived expected values.
        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; C = 1'b0; sub = 1'b0;
        #3;
        check("reset in_ready",  in_ready,  1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset S",         S,         16'h0000);
        check("reset flags",     {c4, v, z, n}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Table: the directed values must also agree with the model, then the
        // DUT is checked against the model in run_op.
        for (int i = 0; i < 7; i++) begin
            model(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub, t.s, t.c4, t.v, t.z, t.n);
            check($sformatf("vec%0d table S", i), {t.s, t.c4, t.v, t.z, t.n},
                  {vecs[i].s, vecs[i].c4, vecs[i].v, vecs[i].z, vecs[i].n});
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub, 0);
        end

        // Randomized operations with random retire delay.
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_op($sformatf("rand%0d", k), ra, rb, rc, rs, int'($urandom_range(0, 2)));
        end

        // Backpressure: result held, new operands offered but not taken.
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; C = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NCHUNK) @(negedge clk);
        check("bp out_valid", out_valid, 1'b1);
        A = 16'hFFFF; B = 16'hFFFF; C = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d S", k), S, 16'h2345);
            check($sformatf("bp%0d flags", k), {c4, v, z, n}, 4'b0000);
            check($sformatf("bp%0d ready/valid", k), {in_ready, out_valid}, 2'b01);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp in_ready after retire", in_ready, 1'b1);
        check("bp out_valid after retire", out_valid, 1'b0);
        check("bp S held after retire", S, 16'h2345);

        // out_ready in IDLE has no effect.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle out_ready ignored", {in_ready, out_valid, S}, {2'b10, 16'h2345});

        // Mid-operation reset: leave nonzero S and flags first.
        run_op("pre-reset", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; C = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst S",         S,         16'h0000);
        check("midrst flags",     {c4, v, z, n}, 4'b0000);
        check("midrst in_ready",  in_ready,  1'b1);
        repeat (2) @(negedge clk);
        check("midrst held", {out_valid, S}, {1'b0, 16'h0000});
        rst = 1'b0;
        run_op("after-reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_chunked_addsub
